priority_enc_queue: RTL and testbench

- Sequential counterpart to the lab's 2-to-4 enable decoder: an N-to-log2(N) priority encoder that accumulates multi-hot request bits into a pending register.
- Serves pending bits one at a time, highest index first, as binary codes over a valid/ready handshake.
- Each served code is suitable for driving the decoder's select input downstream.
- Sits between request sources (buttons, interrupt lines) and a consumer that accepts one code per handshake.

---
 rtl/priority_enc_queue_if.sv | 24 ++
 rtl/priority_enc_queue.sv | 55 +++++
 tb/tb_priority_enc_queue.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/priority_enc_queue_if.sv
// Request/code bundle for priority_enc_queue.
// master is the encoder side, slave the source/consumer side.
interface priority_enc_queue_if #(
  parameter int N = 4,
  parameter int W = 2
);
  logic         en;
  logic [N-1:0] req;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] code;
  logic [N-1:0] pending;
  logic         busy;

  modport master (
    input  en, req, out_ready,
    output out_valid, code, pending, busy
  );

  modport slave (
    output en, req, out_ready,
    input  out_valid, code, pending, busy
  );
endinterface

// File: rtl/priority_enc_queue.sv
// Accumulating N-to-log2(N) priority encoder.
// Serves pending requests highest index first over valid/ready.
module priority_enc_queue #(
  parameter int N = 4,
  parameter int W = 2
) (
  input logic                clk,
  input logic                rst_n,
  priority_enc_queue_if.master bus
);

  logic [N-1:0] pend_q;
  logic [W-1:0] code_q;
  logic         vld_q;

  logic [N-1:0] comb;
  logic [W-1:0] hi;
  logic         slot_free;

  assign comb      = pend_q | (bus.en ? bus.req : '0);
  assign slot_free = !vld_q || bus.out_ready;

  // Ascending scan: the last set bit seen is the highest.
  always_comb begin
    hi = '0;
    for (int i = 0; i < N; i++) begin
      if (comb[i]) hi = W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      code_q <= '0;
      vld_q  <= 1'b0;
    end else if (slot_free) begin
      if (|comb) begin
        code_q <= hi;
        vld_q  <= 1'b1;
        pend_q <= comb & ~(N'(1) << hi);
      end else begin
        vld_q  <= 1'b0;
        pend_q <= '0;
      end
    end else begin
      pend_q <= comb;
    end
  end

  assign bus.out_valid = vld_q;
  assign bus.code      = code_q;
  assign bus.pending   = pend_q;
  assign bus.busy      = vld_q | (|pend_q);

endmodule

// File: tb/tb_priority_enc_queue.sv
// Directed bench for priority_enc_queue.
// Inputs change 1ns after posedge; outputs sampled at that point.
module tb_priority_enc_queue;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  priority_enc_queue_if #(.N(4), .W(2)) bus ();

  priority_enc_queue #(.N(4), .W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.en = 1'b1;
    bus.req = 4'b0000;
    bus.out_ready = 1'b1;
    step();
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", bus.out_valid); end
    tests++; if (bus.code !== 2'b00) begin fails++; $display("FAIL rst_code got %b want 00", bus.code); end
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL rst_pending got %b want 0000", bus.pending); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rst_busy got %b want 0", bus.busy); end
    rst_n = 1'b1;
    step();
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL idle_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b want 1", bus.out_valid); end
    tests++; if (bus.code !== 2'b10) begin fails++; $display("FAIL single_code got %b want 10", bus.code); end
    tests++; if (bus.pending !== 4'b0000) begin fails++; $display("FAIL single_pending got %b want 0000", bus.pending); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_after got %b want 0", bus.out_valid); end
  endtask

  task automatic test_multi_drain();
    bit [1:0] exp_code [3] = '{2'b11, 2'b01, 2'b00};
    bit [3:0] exp_pend [3] = '{4'b0011, 4'b0001, 4'b0000};
    bus.req = 4'b1011;
    step();
    bus.req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tests++; if (bus.out_valid !== 1'b1 || bus.code !== exp_code[i]) begin fails++; $display("FAIL drain_code[%0d] got v=%b c=%b want v=1 c=%b", i, bus.out_valid, bus.code, exp_code[i]); end
      tests++; if (bus.pending !== exp_pend[i]) begin fails++; $display("FAIL drain_pend[%0d] got %b want %b", i, bus.pending, exp_pend[i]); end
      step();
    end
    tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL drain_end got v=%b b=%b want 0 0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    bus.req = 4'b1001;
    step();
    tests++; if (bus.code !== 2'b11 || bus.pending !== 4'b0001) begin fails++; $display("FAIL bp_first got c=%b p=%b want c=11 p=0001", bus.code, bus.pending); end
    bus.req = 4'b0100;
    step();
    bus.req = 4'b0000;
    tests++; if (bus.code !== 2'b11 || bus.pending !== 4'b0101) begin fails++; $display("FAIL bp_merge got c=%b p=%b want c=11 p=0101", bus.code, bus.pending); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.code !== 2'b11 || bus.pending !== 4'b0101) begin fails++; $display("FAIL bp_hold got v=%b c=%b p=%b want 1 11 0101", bus.out_valid, bus.code, bus.pending); end
    bus.out_ready = 1'b1;
    step();
    tests++; if (bus.code !== 2'b10 || bus.pending !== 4'b0001) begin fails++; $display("FAIL bp_rel1 got c=%b p=%b want c=10 p=0001", bus.code, bus.pending); end
    step();
    tests++; if (bus.out_valid !== 1'b1 || bus.code !== 2'b00) begin fails++; $display("FAIL bp_rel2 got v=%b c=%b want 1 00", bus.out_valid, bus.code); end
    step();
    tests++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL bp_end got v=%b b=%b want 0 0", bus.out_valid, bus.busy); end
  endtask

  task automatic test_enable();
    bus.en = 1'b0;
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0000;
    tests++; if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000) begin fails++; $display("FAIL en_gate got v=%b p=%b want 0 0000", bus.out_valid, bus.pending); end
    bus.en = 1'b1;
    bus.req = 4'b0010;
    step();
    bus.req = 4'b0000;
    tests++; if (bus.out_valid !== 1'b1 || bus.code !== 2'b01) begin fails++; $display("FAIL en_on got v=%b c=%b want 1 01", bus.out_valid, bus.code); end
    step();
  endtask

  task automatic test_async_reset();
    bus.req = 4'b1111;
    step();
    bus.req = 4'b0000;
    tests++; if (bus.code !== 2'b11 || bus.pending !== 4'b0111) begin fails++; $display("FAIL ar_first got c=%b p=%b want c=11 p=0111", bus.code, bus.pending); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.out_valid !== 1'b0 || bus.pending !== 4'b0000) begin fails++; $display("FAIL ar_async got v=%b p=%b want 0 0000", bus.out_valid, bus.pending); end
    tests++; if (bus.busy !== 1'b0 || bus.code !== 2'b00) begin fails++; $display("FAIL ar_busy got b=%b c=%b want 0 00", bus.busy, bus.code); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL ar_quiet[%0d] got %b want 0", i, bus.out_valid); end
    end
  endtask

  task automatic test_back_to_back();
    bus.req = 4'b1000;
    step();
    bus.req = 4'b1000;
    tests++; if (bus.code !== 2'b11) begin fails++; $display("FAIL b2b_0 got %b want 11", bus.code); end
    step();
    bus.req = 4'b0001;
    tests++; if (bus.out_valid !== 1'b1 || bus.code !== 2'b11) begin fails++; $display("FAIL b2b_1 got v=%b c=%b want 1 11", bus.out_valid, bus.code); end
    step();
    bus.req = 4'b0000;
    tests++; if (bus.code !== 2'b00) begin fails++; $display("FAIL b2b_2 got %b want 00", bus.code); end
    step();
    tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got %b want 0", bus.out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_single();
    test_multi_drain();
    test_backpressure();
    test_enable();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
